// File: rtl/video_timing_ctrl_8port.sv
// video_timing_ctrl_8port
// Frame timing generator for the 8-pixel-per-clock video path. It produces
// vs/hs/de plus the pixel-group and line indices for one clock per pixel
// group, and sequences exactly one frame (or a run of frames) per start.
// Optional feature macro: TIMING_CTRL_FRAME_LIMIT_EN. When it is defined,
// RUN auto-stops after NUM_FRAMES frames (0 = unlimited). Without it, RUN
// continues until stop and then drains the current frame.
module video_timing_ctrl_8port #(
  parameter int H_ACTIVE   = 240,
  parameter int H_FP       = 11,
  parameter int H_SYNC     = 6,
  parameter int H_BP       = 18,
  parameter int V_ACTIVE   = 1080,
  parameter int V_FP       = 4,
  parameter int V_SYNC     = 5,
  parameter int V_BP       = 36,
  parameter int NUM_FRAMES = 1
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        start,
  input  logic        stop,
  output logic        vs_out,
  output logic        hs_out,
  output logic        de_out,
  output logic [7:0]  x_out,
  output logic [10:0] y_out,
  output logic        frame_done,
  output logic        busy,
  output logic [15:0] frame_cnt
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] H_LAST     = 12'(H_TOT - 1);
  localparam logic [11:0] V_LAST     = 12'(V_TOT - 1);
  localparam logic [11:0] H_DE_END   = 12'(H_ACTIVE);
  localparam logic [11:0] V_DE_END   = 12'(V_ACTIVE);
  localparam logic [11:0] H_SYNC_BEG = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] H_SYNC_END = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] V_SYNC_BEG = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] V_SYNC_END = 12'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [15:0] FRAME_LIMIT = 16'(NUM_FRAMES);

`ifdef TIMING_CTRL_FRAME_LIMIT_EN
  localparam logic LIMIT_EN = 1'b1;
`else
  localparam logic LIMIT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t      state, state_nxt;
  logic        stop_pend;
  logic [11:0] h_cnt_p0;
  logic [11:0] v_cnt_p0;
  logic        at_wrap;
  logic        limit_hit;
  logic [15:0] frame_cnt_inc;
  logic        de_dec, hs_dec, vs_dec;

  // Wrap detection, saturating frame count, frame-limit test and next state
  always_comb begin
    state_nxt     = state;
    at_wrap       = (state != IDLE) && (h_cnt_p0 == H_LAST) && (v_cnt_p0 == V_LAST);
    frame_cnt_inc = (frame_cnt == 16'hFFFF) ? frame_cnt : frame_cnt + 16'd1;
    limit_hit     = LIMIT_EN && (FRAME_LIMIT != 16'd0) && (frame_cnt_inc == FRAME_LIMIT);
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN: begin
        if (at_wrap && limit_hit) state_nxt = IDLE;
        else if (stop || stop_pend) state_nxt = DRAIN;
      end
      DRAIN:   if (at_wrap) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control state: FSM register, busy flag and a stop captured together with start
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state     <= IDLE;
      busy      <= 1'b0;
      stop_pend <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != IDLE);
      if (state == IDLE && start) stop_pend <= stop;
      else if (state == RUN)      stop_pend <= 1'b0;
    end
  end

  // ---- stage p0: raster counters and completed-frame count ----
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      h_cnt_p0  <= 12'd0;
      v_cnt_p0  <= 12'd0;
      frame_cnt <= 16'd0;
    end else if (state == IDLE) begin
      if (start) begin
        h_cnt_p0  <= 12'd0;
        v_cnt_p0  <= 12'd0;
        frame_cnt <= 16'd0;
      end
    end else begin
      if (h_cnt_p0 == H_LAST) begin
        h_cnt_p0 <= 12'd0;
        v_cnt_p0 <= (v_cnt_p0 == V_LAST) ? 12'd0 : v_cnt_p0 + 12'd1;
      end else begin
        h_cnt_p0 <= h_cnt_p0 + 12'd1;
      end
      if (at_wrap) frame_cnt <= frame_cnt_inc;
    end
  end

  // Position decode of the current counters
  always_comb begin
    de_dec = (h_cnt_p0 < H_DE_END) && (v_cnt_p0 < V_DE_END);
    hs_dec = (h_cnt_p0 >= H_SYNC_BEG) && (h_cnt_p0 < H_SYNC_END);
    vs_dec = (v_cnt_p0 >= V_SYNC_BEG) && (v_cnt_p0 < V_SYNC_END);
  end

  // ---- stage p1: registered timing outputs, one cycle behind the counters ----
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      de_out     <= 1'b0;
      hs_out     <= 1'b0;
      vs_out     <= 1'b0;
      x_out      <= 8'd0;
      y_out      <= 11'd0;
      frame_done <= 1'b0;
    end else if (state != IDLE) begin
      de_out     <= de_dec;
      hs_out     <= hs_dec;
      vs_out     <= vs_dec;
      x_out      <= de_dec ? h_cnt_p0[7:0] : 8'd0;
      y_out      <= de_dec ? v_cnt_p0[10:0] : 11'd0;
      frame_done <= at_wrap;
    end else begin
      de_out     <= 1'b0;
      hs_out     <= 1'b0;
      vs_out     <= 1'b0;
      x_out      <= 8'd0;
      y_out      <= 11'd0;
      frame_done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_video_timing_ctrl_8port.sv
// Directed bench for video_timing_ctrl_8port on a tiny 8x6 raster
// (48 cycles per frame). Expected outputs for every sampled cycle come from
// a position model: output cycle k (k >= 1 after the start edge) shows
// raster position k-1.
module tb_video_timing_ctrl_8port;

`ifdef TIMING_CTRL_FRAME_LIMIT_EN
  localparam bit LIM = 1'b1;
`else
  localparam bit LIM = 1'b0;
`endif
  localparam int FRAME = 48;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        vs_out, hs_out, de_out, frame_done, busy;
  logic [7:0]  x_out;
  logic [10:0] y_out;
  logic [15:0] frame_cnt;

  int vectors = 0;
  int miscompares = 0;
  int cyc, run_len, de_n, hs_n, vs_n, fd_n, fd_last, busy_fall;
  logic prev_busy;

  video_timing_ctrl_8port #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .NUM_FRAMES(1)
  ) dut (
    .clk(clk), .rst_b(rst_b), .start(start), .stop(stop),
    .vs_out(vs_out), .hs_out(hs_out), .de_out(de_out),
    .x_out(x_out), .y_out(y_out), .frame_done(frame_done),
    .busy(busy), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " vs"}, 32'(vs_out), 0);
    chk({tag, " hs"}, 32'(hs_out), 0);
    chk({tag, " de"}, 32'(de_out), 0);
    chk({tag, " x"}, 32'(x_out), 0);
    chk({tag, " y"}, 32'(y_out), 0);
    chk({tag, " fd"}, 32'(frame_done), 0);
    chk({tag, " busy"}, 32'(busy), 0);
    chk({tag, " fcnt"}, 32'(frame_cnt), 0);
  endtask

  // start (optionally with stop) sampled at edge E0; cycle count restarts here
  task automatic kick(input logic with_stop);
    start = 1'b1;
    stop  = with_stop;
    @(posedge clk); #1;
    start = 1'b0;
    stop  = 1'b0;
    cyc = 0; de_n = 0; hs_n = 0; vs_n = 0; fd_n = 0;
    fd_last = -1; busy_fall = -1; prev_busy = 1'b1;
    chk("E0 busy", 32'(busy), 1);
    chk("E0 de", 32'(de_out), 0);
    chk("E0 fcnt", 32'(frame_cnt), 0);
  endtask

  task automatic tick();
    int p, h, v;
    logic e_de, e_hs, e_vs, e_fd, e_busy;
    int e_x, e_y, e_fc;
    string t;
    @(posedge clk); #1;
    cyc++;
    e_de = 0; e_hs = 0; e_vs = 0; e_fd = 0; e_busy = 0; e_x = 0; e_y = 0;
    if (cyc <= run_len) begin
      p = (cyc - 1) % FRAME;
      h = p % 8;
      v = p / 8;
      e_de = (h < 4) && (v < 3);
      e_hs = (h == 5) || (h == 6);
      e_vs = (v == 4);
      e_fd = (p == FRAME - 1);
      e_x  = e_de ? h : 0;
      e_y  = e_de ? v : 0;
      e_busy = (cyc < run_len);
      e_fc = cyc / FRAME;
    end else begin
      e_fc = run_len / FRAME;
    end
    t = $sformatf("c%0d", cyc);
    chk({t, " de"}, 32'(de_out), 32'(e_de));
    chk({t, " hs"}, 32'(hs_out), 32'(e_hs));
    chk({t, " vs"}, 32'(vs_out), 32'(e_vs));
    chk({t, " x"}, 32'(x_out), 32'(e_x));
    chk({t, " y"}, 32'(y_out), 32'(e_y));
    chk({t, " fd"}, 32'(frame_done), 32'(e_fd));
    chk({t, " busy"}, 32'(busy), 32'(e_busy));
    chk({t, " fcnt"}, 32'(frame_cnt), 32'(e_fc));
    if (de_out) de_n++;
    if (hs_out) hs_n++;
    if (vs_out) vs_n++;
    if (frame_done) begin fd_n++; fd_last = cyc; end
    if (prev_busy && !busy && busy_fall < 0) busy_fall = cyc;
    prev_busy = busy;
  endtask

  task automatic chk_run(input string tag, input int frames);
    chk({tag, " de count"}, 32'(de_n), 32'(12 * frames));
    chk({tag, " hs count"}, 32'(hs_n), 32'(12 * frames));
    chk({tag, " vs count"}, 32'(vs_n), 32'(8 * frames));
    chk({tag, " fd count"}, 32'(fd_n), 32'(frames));
    chk({tag, " fd last"}, 32'(fd_last), 32'(FRAME * frames));
    chk({tag, " busy fall"}, 32'(busy_fall), 32'(FRAME * frames));
    chk({tag, " fcnt end"}, 32'(frame_cnt), 32'(frames));
  endtask

  initial begin
    // 1: reset values while start toggles under reset
    for (int i = 0; i < 4; i++) begin
      start = ~start;
      @(posedge clk); #1;
      chk_zero($sformatf("rst%0d", i));
    end
    start = 1'b0;
    rst_b = 1'b1;
    @(posedge clk); #1;
    chk_zero("after release");

    // 2: single frame (frame limit, or stop early in frame 1)
    run_len = FRAME;
    kick(1'b0);
    for (int i = 0; i < 52; i++) begin
      if (!LIM && cyc == 10) stop = 1'b1;
      if (cyc == 11) stop = 1'b0;
      tick();
    end
    chk_run("single", 1);

    // 3: continuous run, stop in frame 2 at output cycle 70
    run_len = LIM ? FRAME : 2 * FRAME;
    kick(1'b0);
    for (int i = 0; i < 100; i++) begin
      if (cyc == 69) stop = 1'b1;
      if (cyc == 71) stop = 1'b0;
      tick();
    end
    chk_run("two", LIM ? 1 : 2);

    // 4: start re-asserted mid-frame, stop pulsed again during DRAIN
    run_len = FRAME;
    kick(1'b0);
    for (int i = 0; i < 52; i++) begin
      if (cyc == 20) start = 1'b1;
      if (cyc == 23) start = 1'b0;
      if (cyc == 30) stop = 1'b1;
      if (cyc == 31) stop = 1'b0;
      if (cyc == 40) begin stop = 1'b1; start = 1'b1; end
      if (cyc == 41) begin stop = 1'b0; start = 1'b0; end
      tick();
    end
    chk_run("ignored", 1);

    // 5: asynchronous reset at position v=1, h=2
    run_len = FRAME;
    kick(1'b0);
    for (int i = 0; i < 11; i++) tick();
    chk("pre-reset de", 32'(de_out), 1);
    chk("pre-reset x", 32'(x_out), 2);
    chk("pre-reset y", 32'(y_out), 1);
    #2 rst_b = 1'b0;
    #1 chk_zero("async rst");
    @(posedge clk); #1;
    chk_zero("held rst");
    rst_b = 1'b1;
    @(posedge clk); #1;
    chk_zero("rst released");
    run_len = FRAME;
    kick(1'b0);
    for (int i = 0; i < 52; i++) begin
      if (!LIM && cyc == 5) stop = 1'b1;
      if (cyc == 6) stop = 1'b0;
      tick();
    end
    chk_run("restart", 1);

    // 6: start and stop high together for one cycle in IDLE
    run_len = FRAME;
    kick(1'b1);
    for (int i = 0; i < 52; i++) tick();
    chk_run("both", 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
